// File: rtl/uart_pkg.sv
// Shared UART timing and state definitions, so RX and a future TX derive
// identical bit timing from the same clock/baud pair.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_e;

  localparam int unsigned UART_DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned UART_DEF_BAUD     = 115_200;

  // Clocks per bit, truncated.
  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Offset from the start edge to the middle of the start bit.
  function automatic int unsigned uart_half(input int unsigned clk_freq,
                                            input int unsigned baud);
    return uart_div(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received byte and status pulses out.
interface uart_rx_if;
  logic       in_data;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       frame_err;
  logic       busy;

  modport master (input in_data, output out_byte, out_valid, frame_err, busy);
  modport slave  (output in_data, input out_byte, out_valid, frame_err, busy);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a
// parameter so an idle-high line does not look like a start edge after reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a single clocks-per-bit counter,
// one-cycle out_valid / frame_err pulses, break handled by waiting for idle.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = UART_DEF_CLK_FREQ,
  parameter int unsigned BAUD     = UART_DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_rx_if.master  bus
);

  localparam int unsigned DIV  = uart_div(CLK_FREQ, BAUD);
  localparam int unsigned HALF = uart_half(CLK_FREQ, BAUD);
  localparam int unsigned CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.in_data),
    .q_o   (rx_s)
  );

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    idx_q,   idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q,  byte_d;
  logic          valid_q, valid_d;
  logic          ferr_q,  ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A line already high again at mid start bit was only a glitch.
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == DIV_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == DIV_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A break must not retrigger START until the line has gone idle.
      ST_WAIT_HIGH: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.out_byte  = byte_q;
  assign bus.out_valid = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
